// File: rtl/alu_issue_if.sv
// ID/EX issue-stage bundle: IF/ID instruction, register file read port,
// writeback forwarding sources, and the registered ID/EX outputs that
// feed the ALU. The stage itself is the slave; its environment is the master.
interface alu_issue_if;
    // IF/ID side
    logic        id_valid;
    logic [31:0] id_instr;
    logic        flush;
    logic        stall;

    // Register file read ports
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rf_data_a;
    logic [31:0] rf_data_b;

    // Forwarding sources
    logic [31:0] alu_result;
    logic        mem_regwrite;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;

    // ID/EX pipeline register outputs
    logic        ex_valid;
    logic [31:0] BussA;
    logic [31:0] BussB;
    logic [1:0]  ALUControl;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic [31:0] ex_store_data;

    modport slave (
        input  id_valid, id_instr, flush,
        input  rf_data_a, rf_data_b,
        input  alu_result,
        input  mem_regwrite, mem_rd, mem_result,
        input  wb_regwrite, wb_rd, wb_result,
        output stall, rs_addr, rt_addr,
        output ex_valid, BussA, BussB, ALUControl, ex_rd,
        output ex_regwrite, ex_memread, ex_memwrite, ex_store_data
    );

    modport master (
        output id_valid, id_instr, flush,
        output rf_data_a, rf_data_b,
        output alu_result,
        output mem_regwrite, mem_rd, mem_result,
        output wb_regwrite, wb_rd, wb_result,
        input  stall, rs_addr, rt_addr,
        input  ex_valid, BussA, BussB, ALUControl, ex_rd,
        input  ex_regwrite, ex_memread, ex_memwrite, ex_store_data
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage for the five-stage MIPS pipeline: decodes the IF/ID
// instruction into an ALU control code, forwards both source operands from
// EX/MEM/WB, detects load-use hazards and registers everything into ID/EX.
module alu_issue_stage (
    input  logic        clk,
    input  logic        reset,
    alu_issue_if.slave  bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_XOR = 2'b01,
        ALU_SUB = 2'b10,
        ALU_SLT = 2'b11
    } alu_ctrl_e;

    // Instruction fields
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd_field;
    logic [31:0] imm_sext;
    logic        unused_shamt;

    assign opcode       = bus.id_instr[31:26];
    assign rs           = bus.id_instr[25:21];
    assign rt           = bus.id_instr[20:16];
    assign rd_field     = bus.id_instr[15:11];
    assign funct        = bus.id_instr[5:0];
    assign imm_sext     = {{16{bus.id_instr[15]}}, bus.id_instr[15:0]};
    assign unused_shamt = ^bus.id_instr[10:6];

    assign bus.rs_addr = rs;
    assign bus.rt_addr = rt;

    // ID/EX pipeline register
    logic        ex_valid_q,    ex_valid_d;
    logic        ex_regwrite_q, ex_regwrite_d;
    logic        ex_memread_q,  ex_memread_d;
    logic        ex_memwrite_q, ex_memwrite_d;
    logic [31:0] bussa_q,       bussa_d;
    logic [31:0] bussb_q,       bussb_d;
    logic [31:0] store_data_q,  store_data_d;
    logic [4:0]  ex_rd_q,       ex_rd_d;
    alu_ctrl_e   alu_ctrl_q,    alu_ctrl_d;

    // Decode results
    alu_ctrl_e   dec_ctrl;
    logic        dec_regwrite;
    logic        dec_memread;
    logic        dec_memwrite;
    logic        dec_use_imm;
    logic        dec_reads_rt;
    logic [4:0]  dec_rd;

    // Decode opcode/funct into ALU control, destination and memory controls
    always_comb begin
        dec_ctrl     = ALU_ADD;
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_use_imm  = 1'b0;
        dec_reads_rt = 1'b1;   // conservative: unknown encodings are treated as rt readers
        dec_rd       = 5'd0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: begin
                        dec_ctrl     = ALU_ADD;
                        dec_regwrite = 1'b1;
                        dec_rd       = rd_field;
                    end
                    FN_SUB: begin
                        dec_ctrl     = ALU_SUB;
                        dec_regwrite = 1'b1;
                        dec_rd       = rd_field;
                    end
                    FN_XOR: begin
                        dec_ctrl     = ALU_XOR;
                        dec_regwrite = 1'b1;
                        dec_rd       = rd_field;
                    end
                    FN_SLT: begin
                        dec_ctrl     = ALU_SLT;
                        dec_regwrite = 1'b1;
                        dec_rd       = rd_field;
                    end
                    default: ;  // unknown funct decodes as a NOP
                endcase
            end
            OP_ADDI: begin
                dec_use_imm  = 1'b1;
                dec_reads_rt = 1'b0;
                dec_regwrite = 1'b1;
                dec_rd       = rt;
            end
            OP_LW: begin
                dec_use_imm  = 1'b1;
                dec_reads_rt = 1'b0;
                dec_regwrite = 1'b1;
                dec_memread  = 1'b1;
                dec_rd       = rt;
            end
            OP_SW: begin
                dec_use_imm  = 1'b1;
                dec_memwrite = 1'b1;
            end
            default: ;
        endcase
        // Writes to $0 are architecturally discarded
        if (dec_rd == 5'd0) begin
            dec_regwrite = 1'b0;
        end
    end

    // Forwarding: the EX stage only forwards ALU results, never load data
    logic        ex_fwd_ok;
    logic [4:0]  src_addr [2];
    logic [31:0] src_rf   [2];
    logic [31:0] src_fwd  [2];

    assign ex_fwd_ok   = ex_valid_q & ex_regwrite_q & ~ex_memread_q;
    assign src_addr[0] = rs;
    assign src_addr[1] = rt;
    assign src_rf[0]   = bus.rf_data_a;
    assign src_rf[1]   = bus.rf_data_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            // Resolve one source operand: $0, then EX, MEM, WB, register file
            always_comb begin
                src_fwd[gi] = src_rf[gi];
                if (src_addr[gi] == 5'd0) begin
                    src_fwd[gi] = 32'd0;
                end else if (ex_fwd_ok && ex_rd_q == src_addr[gi]) begin
                    src_fwd[gi] = bus.alu_result;
                end else if (bus.mem_regwrite && bus.mem_rd == src_addr[gi]) begin
                    src_fwd[gi] = bus.mem_result;
                end else if (bus.wb_regwrite && bus.wb_rd == src_addr[gi]) begin
                    src_fwd[gi] = bus.wb_result;
                end
            end
        end
    endgenerate

    // Load-use hazard: the load in EX has no data yet, so hold IF/ID one cycle
    logic hazard_rs;
    logic hazard_rt;
    logic stall;
    logic load_en;

    assign hazard_rs = (ex_rd_q == rs);
    assign hazard_rt = dec_reads_rt & (ex_rd_q == rt);
    assign stall     = bus.id_valid & ~bus.flush & ex_valid_q & ex_memread_q
                       & (ex_rd_q != 5'd0) & (hazard_rs | hazard_rt);
    assign load_en   = bus.id_valid & ~bus.flush & ~stall;
    assign bus.stall = stall;

    // Next ID/EX contents: decoded instruction, or a bubble that keeps data fields
    always_comb begin
        ex_valid_d    = 1'b0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
        ex_memwrite_d = 1'b0;
        bussa_d       = bussa_q;
        bussb_d       = bussb_q;
        store_data_d  = store_data_q;
        ex_rd_d       = ex_rd_q;
        alu_ctrl_d    = alu_ctrl_q;
        if (load_en) begin
            ex_valid_d    = 1'b1;
            ex_regwrite_d = dec_regwrite;
            ex_memread_d  = dec_memread;
            ex_memwrite_d = dec_memwrite;
            bussa_d       = src_fwd[0];
            bussb_d       = dec_use_imm ? imm_sext : src_fwd[1];
            store_data_d  = src_fwd[1];
            ex_rd_d       = dec_rd;
            alu_ctrl_d    = dec_ctrl;
        end
    end

    // ID/EX register with immediate clear on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
            bussa_q       <= 32'd0;
            bussb_q       <= 32'd0;
            store_data_q  <= 32'd0;
            ex_rd_q       <= 5'd0;
            alu_ctrl_q    <= ALU_ADD;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_memwrite_q <= ex_memwrite_d;
            bussa_q       <= bussa_d;
            bussb_q       <= bussb_d;
            store_data_q  <= store_data_d;
            ex_rd_q       <= ex_rd_d;
            alu_ctrl_q    <= alu_ctrl_d;
        end
    end

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_regwrite   = ex_regwrite_q;
    assign bus.ex_memread    = ex_memread_q;
    assign bus.ex_memwrite   = ex_memwrite_q;
    assign bus.BussA         = bussa_q;
    assign bus.BussB         = bussb_q;
    assign bus.ex_store_data = store_data_q;
    assign bus.ex_rd         = ex_rd_q;
    assign bus.ALUControl    = alu_ctrl_q;
endmodule
